// File: rtl/expr_eval_ctrl.sv
// Character-stream expression checker/evaluator.
// Single-digit operands, '*' binds tighter than '+', '=' ends.
module expr_eval_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_result,
  output logic             out_err,
  input  logic             out_ready,
  output logic [CNT_W-1:0] expr_cnt
);

  typedef enum logic [1:0] {
    EXP_D,
    GOT_D,
    ERR,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    C_DIG,
    C_ADD,
    C_MUL,
    C_EQ,
    C_OTH
  } cls_t;

  state_t           state, state_n;
  cls_t             cls;
  logic [WIDTH-1:0] sum, sum_n;
  logic [WIDTH-1:0] term, term_n;
  logic             mul_pend, mul_n;
  logic [WIDTH-1:0] res_n;
  logic             err_n;
  logic [CNT_W-1:0] cnt_n;
  logic [WIDTH-1:0] dig;
  logic             acc;

  assign in_ready  = (state != DONE);
  assign out_valid = (state == DONE);
  assign acc       = in_valid && in_ready;
  assign dig       = WIDTH'(in_data[3:0]);

  always_comb begin
    cls = C_OTH;
    unique case (1'b1)
      (in_data >= 8'h30 && in_data <= 8'h39):
        cls = C_DIG;
      (in_data == 8'h2b): cls = C_ADD;
      (in_data == 8'h2a): cls = C_MUL;
      (in_data == 8'h3d): cls = C_EQ;
      default:            cls = C_OTH;
    endcase
  end

  always_comb begin
    state_n = state;
    sum_n   = sum;
    term_n  = term;
    mul_n   = mul_pend;
    res_n   = out_result;
    err_n   = out_err;
    cnt_n   = expr_cnt;
    case (state)
      EXP_D: begin
        if (acc) begin
          case (cls)
            C_DIG: begin
              term_n  = mul_pend ? term * dig : dig;
              mul_n   = 1'b0;
              state_n = GOT_D;
            end
            C_EQ: begin
              err_n   = 1'b1;
              res_n   = '0;
              state_n = DONE;
            end
            default: state_n = ERR;
          endcase
        end
      end
      GOT_D: begin
        if (acc) begin
          case (cls)
            C_ADD: begin
              sum_n   = sum + term;
              state_n = EXP_D;
            end
            C_MUL: begin
              mul_n   = 1'b1;
              state_n = EXP_D;
            end
            C_EQ: begin
              res_n   = sum + term;
              err_n   = 1'b0;
              state_n = DONE;
            end
            default: state_n = ERR;
          endcase
        end
      end
      ERR: begin
        if (acc && cls == C_EQ) begin
          err_n   = 1'b1;
          res_n   = '0;
          state_n = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          cnt_n   = expr_cnt + CNT_W'(1);
          sum_n   = '0;
          term_n  = '0;
          mul_n   = 1'b0;
          state_n = EXP_D;
        end
      end
      default: state_n = ERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state      <= EXP_D;
      sum        <= '0;
      term       <= '0;
      mul_pend   <= 1'b0;
      out_result <= '0;
      out_err    <= 1'b0;
      expr_cnt   <= '0;
    end else begin
      state      <= state_n;
      sum        <= sum_n;
      term       <= term_n;
      mul_pend   <= mul_n;
      out_result <= res_n;
      out_err    <= err_n;
      expr_cnt   <= cnt_n;
    end
  end

endmodule

// File: tb/tb_expr_eval_ctrl.sv
// Directed bench for expr_eval_ctrl.
// Hand-computed expected records checked with assertions.
module tb_expr_eval_ctrl;

  logic       clk = 1'b0;
  logic       clr;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_result;
  logic       out_err;
  logic       out_ready;
  logic [7:0] expr_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  expr_eval_ctrl #(.WIDTH(8), .CNT_W(8)) dut (
    .clk        (clk),
    .clr        (clr),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_result (out_result),
    .out_err    (out_err),
    .out_ready  (out_ready),
    .expr_cnt   (expr_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_char(input logic [7:0] c);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = c;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) chk("in_ready_timeout", 32'(in_ready), 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++)
      send_char(s[i]);
  endtask

  task automatic run(input string s,
                     input logic [7:0] res,
                     input logic err);
    out_ready = 1'b1;
    send_str(s);
    chk({s, " valid"}, 32'(out_valid), 1);
    chk({s, " in_ready"}, 32'(in_ready), 0);
    chk({s, " result"}, 32'(out_result), 32'(res));
    chk({s, " err"}, 32'(out_err), 32'(err));
    step();
    exp_cnt++;
    chk({s, " handoff"}, 32'(out_valid), 0);
    chk({s, " cnt"}, 32'(expr_cnt), 32'(exp_cnt));
  endtask

  initial begin
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    step();
    step();
    chk("rst valid", 32'(out_valid), 0);
    chk("rst result", 32'(out_result), 0);
    chk("rst err", 32'(out_err), 0);
    chk("rst cnt", 32'(expr_cnt), 0);
    chk("rst in_ready", 32'(in_ready), 1);
    clr = 1'b1;
    step();

    run("1+2*3=", 8'd7, 1'b0);
    run("2*3*4+5=", 8'd29, 1'b0);
    run("8=", 8'd8, 1'b0);
    run("9*9*9+9*9*9=", 8'd178, 1'b0);

    run("+1=", 8'd0, 1'b1);
    run("12=", 8'd0, 1'b1);
    run("3+=", 8'd0, 1'b1);
    run("=", 8'd0, 1'b1);
    run("4a=", 8'd0, 1'b1);

    // idle cycles mid-expression keep state
    out_ready = 1'b1;
    send_str("6*");
    repeat (3) step();
    run("3=", 8'd18, 1'b0);

    // stall: record held, input blocked
    out_ready = 1'b0;
    send_str("5=");
    in_valid = 1'b1;
    in_data  = "9";
    for (int i = 0; i < 10; i++) begin
      chk("stall valid", 32'(out_valid), 1);
      chk("stall result", 32'(out_result), 5);
      chk("stall err", 32'(out_err), 0);
      chk("stall in_ready", 32'(in_ready), 0);
      chk("stall cnt", 32'(expr_cnt), 32'(exp_cnt));
      step();
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    exp_cnt++;
    chk("stall handoff", 32'(out_valid), 0);
    chk("stall cnt2", 32'(expr_cnt), 32'(exp_cnt));
    run("=", 8'd0, 1'b1);

    // reset mid-expression drops the pending term
    send_str("7*");
    clr = 1'b0;
    step();
    clr = 1'b1;
    exp_cnt = 0;
    chk("mid rst valid", 32'(out_valid), 0);
    chk("mid rst result", 32'(out_result), 0);
    chk("mid rst err", 32'(out_err), 0);
    chk("mid rst cnt", 32'(expr_cnt), 0);
    run("2=", 8'd2, 1'b0);

    // reset while DONE
    out_ready = 1'b0;
    send_str("4=");
    chk("done valid", 32'(out_valid), 1);
    clr = 1'b0;
    step();
    clr = 1'b1;
    exp_cnt = 0;
    chk("done rst valid", 32'(out_valid), 0);
    chk("done rst in_ready", 32'(in_ready), 1);
    run("1*0+3=", 8'd3, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed hang expected finish");
    $fatal(1, "timeout");
  end

endmodule
